uart_tx_cfg: RTL and testbench

Configurable UART transmitter with an integrated transmit FIFO. It is the successor to the fixed 8N1 transmitter and is used wherever firmware or on-chip logic streams bytes to a host over the Lichee Tang serial link. Character width, parity mode and stop-bit count are set at build time. A small FIFO absorbs bursts so that frames go out back-to-back with no idle gap.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 67 ++++++
 rtl/uart_tx_cfg.sv | 206 ++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the configurable UART transmitter: parity modes,
// FSM state encoding and a frame-length helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Total clock cycles occupied by one frame, start bit through last stop bit.
  function automatic int frame_cycles(input int cpb, input int data_bits,
                                      input int parity, input int stop_bits);
    return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * cpb;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered full flag and occupancy count.
// Storage is not reset; only pointers and flags are.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic [AW:0]      count_n;
  logic             full_q;
  logic             do_push;
  logic             do_pop;

  // Full comes from the previous edge, so a write to a full FIFO is dropped
  // even when a pop frees a slot in the same cycle.
  assign do_push = push && !full_q;
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    count_n = count_q;
    case ({do_push, do_pop})
      2'b10:   count_n = count_q + (AW+1)'(1);
      2'b01:   count_n = count_q - (AW+1)'(1);
      default: count_n = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_n;
      full_q  <= (count_n == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = full_q;
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with build-time character width, parity and stop bits,
// fed by a small FIFO so queued characters leave as back-to-back frames.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_n,
  input  logic                          i_TX_DV,
  input  logic [DATA_BITS-1:0]          i_TX_Byte,
  output logic                          o_TX_Ready,
  output logic                          o_TX_Serial,
  output logic                          o_TX_Active,
  output logic                          o_TX_Done,
  output logic                          o_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_cfg: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == PAR_ODD) ? ~(^d) : ^d;
  endfunction

  logic [2:0]           state, state_n;
  logic [BW-1:0]        baud_cnt, baud_n;
  logic [CW-1:0]        bit_cnt, bit_n;
  logic                 stop_cnt, stop_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_n;
  logic                 serial_q, serial_n;
  logic                 active_q, active_n;
  logic                 overflow_q;
  logic                 bit_end;
  logic                 load;
  logic                 pop;

  logic [DATA_BITS-1:0] head;
  logic                 full;
  logic                 empty;
  logic [AW:0]          count;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_Clock),
    .rst_n (i_Reset_n),
    .push  (i_TX_DV),
    .wdata (i_TX_Byte),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bit_end = (baud_cnt == BAUD_LAST);

  // The next line level is decided here and registered, so the serial
  // output changes on the same edge the state does and never glitches.
  always_comb begin
    state_n  = state;
    baud_n   = bit_end ? '0 : baud_cnt + BW'(1);
    bit_n    = bit_cnt;
    stop_n   = stop_cnt;
    shreg_n  = shreg;
    par_n    = par_bit;
    serial_n = serial_q;
    active_n = active_q;
    load     = 1'b0;
    pop      = 1'b0;

    case (state)
      ST_IDLE: begin
        baud_n   = '0;
        serial_n = 1'b1;
        active_n = 1'b0;
        if (!empty) load = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_n  = ST_DATA;
          serial_n = shreg[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt == BIT_LAST) begin
            if (PARITY != PAR_NONE) begin
              state_n  = ST_PARITY;
              serial_n = par_bit;
            end else begin
              state_n  = ST_STOP;
              serial_n = 1'b1;
              stop_n   = 1'b0;
            end
          end else begin
            bit_n    = bit_cnt + CW'(1);
            shreg_n  = shreg >> 1;
            serial_n = shreg[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_n  = ST_STOP;
          serial_n = 1'b1;
          stop_n   = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_cnt == STOP_LAST) begin
            if (!empty) begin
              load = 1'b1;
            end else begin
              state_n  = ST_IDLE;
              active_n = 1'b0;
            end
          end else begin
            stop_n = stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n  = ST_IDLE;
        serial_n = 1'b1;
        active_n = 1'b0;
      end
    endcase

    // Frame start is shared by IDLE and the final stop cycle.
    if (load) begin
      pop      = 1'b1;
      shreg_n  = head;
      par_n    = calc_parity(head);
      bit_n    = '0;
      baud_n   = '0;
      stop_n   = 1'b0;
      state_n  = ST_START;
      serial_n = 1'b0;
      active_n = 1'b1;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_cnt    <= bit_n;
      stop_cnt   <= stop_n;
      serial_q   <= serial_n;
      active_q   <= active_n;
      overflow_q <= i_TX_DV && full;
    end
  end

  always_ff @(posedge i_Clock) begin
    shreg   <= shreg_n;
    par_bit <= par_n;
  end

  assign o_TX_Serial  = serial_q;
  assign o_TX_Active  = active_q;
  assign o_TX_Done    = (state == ST_STOP) && bit_end && (stop_cnt == STOP_LAST);
  assign o_Overflow   = overflow_q;
  assign o_TX_Ready   = !full;
  assign o_FIFO_Count = count;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: 8N1, 8O1 and 7E2 instances, each with a
// line decoder that checks every decoded frame against queued expectations.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

  localparam int CPB = 4;

  typedef struct packed {
    logic [8:0] data;
    logic       par;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] dv;
  logic [2:0] ser, act, dn, ovf, rdy;
  logic [7:0] byte_a, byte_b;
  logic [6:0] byte_c;
  logic [2:0] cnt_a, cnt_b, cnt_c;

  int checks   = 0;
  int failures = 0;
  int act_cyc_a = 0;
  int ovf_cnt_a = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_TX_DV(dv[0]), .i_TX_Byte(byte_a),
    .o_TX_Ready(rdy[0]), .o_TX_Serial(ser[0]), .o_TX_Active(act[0]), .o_TX_Done(dn[0]),
    .o_Overflow(ovf[0]), .o_FIFO_Count(cnt_a));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_TX_DV(dv[1]), .i_TX_Byte(byte_b),
    .o_TX_Ready(rdy[1]), .o_TX_Serial(ser[1]), .o_TX_Active(act[1]), .o_TX_Done(dn[1]),
    .o_Overflow(ovf[1]), .o_FIFO_Count(cnt_b));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_TX_DV(dv[2]), .i_TX_Byte(byte_c),
    .o_TX_Ready(rdy[2]), .o_TX_Serial(ser[2]), .o_TX_Active(act[2]), .o_TX_Done(dn[2]),
    .o_Overflow(ovf[2]), .o_FIFO_Count(cnt_c));

  always @(negedge clk) begin
    if (act[0] === 1'b1) act_cyc_a <= act_cyc_a + 1;
    if (ovf[0] === 1'b1) ovf_cnt_a <= ovf_cnt_a + 1;
  end

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic exp_t mk(input logic [8:0] d, input logic p);
    exp_t e;
    e.data = d;
    e.par  = p;
    return e;
  endfunction

  function automatic bit pop_exp(input int id, output exp_t e);
    e = '0;
    case (id)
      0: begin if (q_a.size() == 0) return 1'b0; e = q_a.pop_front(); end
      1: begin if (q_b.size() == 0) return 1'b0; e = q_b.pop_front(); end
      default: begin if (q_c.size() == 0) return 1'b0; e = q_c.pop_front(); end
    endcase
    return 1'b1;
  endfunction

  // Line decoder: samples every cycle of a frame, so a stretched or shortened
  // bit shows up as a width or done-position error.
  task automatic mon(input int id, input int db, input int par, input int sb);
    int nbits;
    int npar;
    logic [8:0] data;
    logic pbit, v, first;
    bit stop_ok, width_ok, done_ok, act_ok, aborted;
    exp_t e;
    string tag;
    tag   = (id == 0) ? "A" : (id == 1) ? "B" : "C";
    npar  = (par != 0) ? 1 : 0;
    nbits = 1 + db + npar + sb;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && ser[id] === 1'b0) begin
        data = '0; pbit = 1'b0; first = 1'b0;
        stop_ok = 1; width_ok = 1; done_ok = 1; act_ok = 1; aborted = 0;
        for (int b = 0; b < nbits && !aborted; b++) begin
          for (int c = 0; c < CPB && !aborted; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst_n !== 1'b1) aborted = 1;
            else begin
              v = ser[id];
              if (c == 0) first = v;
              else if (v !== first) width_ok = 0;
              if (act[id] !== 1'b1) act_ok = 0;
              if (dn[id] !== ((b == nbits - 1 && c == CPB - 1) ? 1'b1 : 1'b0)) done_ok = 0;
            end
          end
          if (!aborted) begin
            if (b >= 1 && b <= db) data[b-1] = first;
            else if (npar == 1 && b == db + 1) pbit = first;
            else if (b > db + npar && first !== 1'b1) stop_ok = 0;
          end
        end
        if (!aborted) begin
          if (!pop_exp(id, e)) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected_frame: got data %0h expected no frame", tag, data);
          end else begin
            chk({tag, "_data"}, 32'(data), 32'(e.data));
            if (npar == 1) chk({tag, "_parity"}, 32'(pbit), 32'(e.par));
            chk({tag, "_stop"}, 32'(stop_ok), 32'd1);
            chk({tag, "_bit_width"}, 32'(width_ok), 32'd1);
            chk({tag, "_done_pos"}, 32'(done_ok), 32'd1);
            chk({tag, "_active_in_frame"}, 32'(act_ok), 32'd1);
          end
        end
      end
    end
  endtask

  task automatic measure(input int id, output int len, output int dones);
    len = 0;
    dones = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (act[id] !== 1'b1) break;
      len++;
      if (dn[id] === 1'b1) dones++;
    end
  endtask

  task automatic wait_inactive(input int id);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (act[id] !== 1'b1) break;
    end
  endtask

  initial begin
    fork
      mon(0, 8, 0, 1);
      mon(1, 8, 1, 1);
      mon(2, 7, 2, 2);
    join_none
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, dones, base, base_ovf, found;
    rst_n = 1'b0; dv = '0; byte_a = '0; byte_b = '0; byte_c = '0;
    repeat (3) @(negedge clk);

    chk("rst_serial", 32'(ser), 32'h7);
    chk("rst_active", 32'(act), 32'h0);
    chk("rst_done", 32'(dn), 32'h0);
    chk("rst_overflow", 32'(ovf), 32'h0);
    chk("rst_ready", 32'(rdy), 32'h7);
    chk("rst_count_a", 32'(cnt_a), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single 8N1 frame, latency from write edge to start bit.
    q_a.push_back(mk(9'h03F, 1'b0));
    byte_a = 8'h3F; dv[0] = 1'b1;
    @(posedge clk); #1;
    chk("lat_serial_n", 32'(ser[0]), 32'd1);
    chk("lat_ready_n", 32'(rdy[0]), 32'd1);
    chk("lat_count_n", 32'(cnt_a), 32'd1);
    @(negedge clk); dv[0] = 1'b0;
    @(posedge clk); #1;
    chk("lat_serial_n1", 32'(ser[0]), 32'd0);
    chk("lat_active_n1", 32'(act[0]), 32'd1);
    chk("lat_ready_n1", 32'(rdy[0]), 32'd1);
    chk("lat_count_n1", 32'(cnt_a), 32'd0);
    measure(0, len, dones);
    chk("A_frame_len", 32'(len), 32'd40);
    chk("A_done_pulses", 32'(dones), 32'd1);

    // Burst of six writes into a depth-4 FIFO.
    base = act_cyc_a;
    base_ovf = ovf_cnt_a;
    for (int i = 0; i < 6; i++) begin
      byte_a = 8'h11 + 8'(i);
      dv[0] = 1'b1;
      if (i < 5) q_a.push_back(mk(9'h011 + 9'(i), 1'b0));
      @(posedge clk); #1;
      if (i == 4) begin
        chk("burst_full_ready", 32'(rdy[0]), 32'd0);
        chk("burst_full_count", 32'(cnt_a), 32'd4);
        chk("burst_no_ovf_yet", 32'(ovf[0]), 32'd0);
      end
      if (i == 5) begin
        chk("burst_ovf", 32'(ovf[0]), 32'd1);
        chk("burst_ovf_count", 32'(cnt_a), 32'd4);
      end
      @(negedge clk);
    end
    dv[0] = 1'b0;
    @(posedge clk); #1;
    chk("burst_ovf_single", 32'(ovf[0]), 32'd0);
    wait_inactive(0);
    chk("burst_active_cycles", 32'(act_cyc_a - base), 32'd200);
    chk("burst_ovf_pulses", 32'(ovf_cnt_a - base_ovf), 32'd1);

    // Push exactly in the final stop cycle with two entries queued.
    byte_a = 8'h21; dv[0] = 1'b1; q_a.push_back(mk(9'h021, 1'b0));
    @(negedge clk); byte_a = 8'h22; q_a.push_back(mk(9'h022, 1'b0));
    @(negedge clk); byte_a = 8'h23; q_a.push_back(mk(9'h023, 1'b0));
    @(posedge clk); #1;
    chk("pp_count_setup", 32'(cnt_a), 32'd2);
    @(negedge clk); dv[0] = 1'b0;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dn[0] === 1'b1) begin found = 1; break; end
    end
    chk("pp_done_seen", 32'(found), 32'd1);
    byte_a = 8'h24; dv[0] = 1'b1; q_a.push_back(mk(9'h024, 1'b0));
    @(posedge clk); #1;
    chk("pp_count_kept", 32'(cnt_a), 32'd2);
    chk("pp_next_start", 32'(ser[0]), 32'd0);
    chk("pp_active_kept", 32'(act[0]), 32'd1);
    @(negedge clk); dv[0] = 1'b0;
    wait_inactive(0);

    // Reset in the middle of a frame with entries queued.
    byte_a = 8'h31; dv[0] = 1'b1;
    @(negedge clk); byte_a = 8'h32;
    @(negedge clk); byte_a = 8'h33;
    @(negedge clk); dv[0] = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_serial", 32'(ser[0]), 32'd1);
    chk("mrst_active", 32'(act[0]), 32'd0);
    chk("mrst_count", 32'(cnt_a), 32'd0);
    chk("mrst_ready", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    base = act_cyc_a;
    repeat (100) @(negedge clk);
    chk("mrst_no_frame", 32'(act_cyc_a - base), 32'd0);
    chk("mrst_line_idle", 32'(ser[0]), 32'd1);
    byte_a = 8'h5A; dv[0] = 1'b1; q_a.push_back(mk(9'h05A, 1'b0));
    @(negedge clk); dv[0] = 1'b0;
    @(negedge clk);
    wait_inactive(0);

    // 8O1 parity cases.
    byte_b = 8'h3F; dv[1] = 1'b1; q_b.push_back(mk(9'h03F, 1'b1));
    @(negedge clk); byte_b = 8'h00; q_b.push_back(mk(9'h000, 1'b1));
    @(negedge clk); byte_b = 8'h01; q_b.push_back(mk(9'h001, 1'b0));
    @(negedge clk); dv[1] = 1'b0;
    @(negedge clk);
    wait_inactive(1);

    // 7E2 frame length and parity cases.
    byte_c = 7'h41; dv[2] = 1'b1; q_c.push_back(mk(9'h041, 1'b0));
    @(posedge clk);
    @(negedge clk); dv[2] = 1'b0;
    @(posedge clk); #1;
    measure(2, len, dones);
    chk("C_frame_len", 32'(len), 32'd44);
    chk("C_done_pulses", 32'(dones), 32'd1);
    byte_c = 7'h07; dv[2] = 1'b1; q_c.push_back(mk(9'h007, 1'b1));
    @(negedge clk); dv[2] = 1'b0;
    @(negedge clk);
    wait_inactive(2);

    repeat (5) @(negedge clk);
    chk("A_pending", 32'(q_a.size()), 32'd0);
    chk("B_pending", 32'(q_b.size()), 32'd0);
    chk("C_pending", 32'(q_c.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
